fwvip_wb_target_mem: RTL and testbench

//  Wishbone classic (non-pipelined) target: a word-organised memory with

---
 rtl/fwvip_wb_target_mem.sv | 126 ++++++++++++
 tb/tb_fwvip_wb_target_mem.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fwvip_wb_target_mem.sv
// Wishbone classic target memory: byte-lane writes, programmable wait states,
// error termination for word indices at or beyond MEM_DEPTH.
module fwvip_wb_target_mem #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [7:0]              wait_cyc,
  input  logic [ADDR_WIDTH-1:0]   adr,
  input  logic [DATA_WIDTH-1:0]   dat_w,
  output logic [DATA_WIDTH-1:0]   dat_r,
  input  logic                    cyc,
  input  logic                    stb,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] sel,
  output logic                    ack,
  output logic                    err
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LSB_W = $clog2(BYTES);
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  state_q;
  logic [7:0]              cnt_q;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic                    we_q, we_d;
  logic [BYTES-1:0]        sel_q, sel_d;
  logic [DATA_WIDTH-1:0]   dat_q, dat_d;
  logic                    ack_q, err_q;
  logic [DATA_WIDTH-1:0]   dat_r_q;

  logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];

  logic                    start;
  logic                    go_resp;
  logic [ADDR_WIDTH-1:0]   word_idx;
  logic                    in_range;
  logic [IDX_W-1:0]        mem_idx;
  logic                    mem_we;

  // In IDLE the live bus attributes are the ones about to be captured; a
  // zero-wait transfer responds straight from them on the capture edge.
  always_comb begin
    adr_d = adr_q;
    we_d  = we_q;
    sel_d = sel_q;
    dat_d = dat_q;
    if (state_q == S_IDLE) begin
      adr_d = adr;
      we_d  = we;
      sel_d = sel;
      dat_d = dat_w;
    end
  end

  assign start    = (state_q == S_IDLE) && cyc && stb;
  assign go_resp  = (start && (wait_cyc == 8'd0)) ||
                    ((state_q == S_WAIT) && cyc && (cnt_q == 8'd1));
  assign word_idx = adr_d >> LSB_W;
  assign in_range = word_idx < ADDR_WIDTH'(MEM_DEPTH);
  assign mem_idx  = word_idx[IDX_W-1:0];
  assign mem_we   = go_resp && in_range && we_d && !reset;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      dat_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_r_q <= '0;
    end else begin
      adr_q   <= adr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_r_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cnt_q   <= wait_cyc;
            state_q <= (wait_cyc != 8'd0) ? S_WAIT : S_RESP;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 8'd1;
          if (!cyc) begin
            state_q <= S_IDLE;
          end else if (cnt_q == 8'd1) begin
            state_q <= S_RESP;
          end
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
      if (go_resp) begin
        ack_q   <= in_range;
        err_q   <= !in_range;
        dat_r_q <= (in_range && !we_d) ? mem_q[mem_idx] : '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int i = 0; i < BYTES; i++) begin
        if (sel_d[i]) mem_q[mem_idx][8*i +: 8] <= dat_d[8*i +: 8];
      end
    end
  end

  assign ack   = ack_q;
  assign err   = err_q;
  assign dat_r = dat_r_q;

endmodule

// File: tb/tb_fwvip_wb_target_mem.sv
// Bench for fwvip_wb_target_mem: directed vector table, hand-written abort and
// reset sequences, then random transfers against a word-array reference model.
module tb_fwvip_wb_target_mem;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  wait_cyc;
  logic [31:0] adr, dat_w, dat_r;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic        ack, err;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem_m [1024];

  always #5 clock = ~clock;

  fwvip_wb_target_mem dut (
    .clock(clock), .reset(reset), .wait_cyc(wait_cyc), .adr(adr),
    .dat_w(dat_w), .dat_r(dat_r), .cyc(cyc), .stb(stb), .we(we),
    .sel(sel), .ack(ack), .err(err)
  );

  typedef struct {
    logic [31:0] a;
    logic        w;
    logic [3:0]  s;
    logic [31:0] d;
    logic [7:0]  wc;
    logic [1:0]  exp_resp;   // {ack, err}
    logic [31:0] exp_dat;
  } vec_t;

  vec_t tv [15];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // Called at posedge+1 with the bus idle. lat counts cycles from the capture
  // edge to the response (1 = the cycle right after capture); -1 if none came.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [3:0] s,
                      input logic [31:0] d, input logic [7:0] wc, input int abort_at,
                      output logic got_ack, output logic got_err,
                      output logic [31:0] got_dat, output int lat, output logic tail_clean);
    got_ack = 1'b0; got_err = 1'b0; got_dat = 32'h0; lat = -1; tail_clean = 1'b1;
    adr = a; we = w; sel = s; dat_w = d; wait_cyc = wc; cyc = 1'b1; stb = 1'b1;
    @(posedge clock); #1;
    adr = $urandom; dat_w = $urandom; sel = 4'($urandom); we = ~w; wait_cyc = 8'($urandom);
    for (int k = 0; k < int'(wc) + 4; k++) begin
      if (ack || err) begin
        got_ack = ack; got_err = err; got_dat = dat_r; lat = k + 1;
        break;
      end
      if (k == abort_at) begin cyc = 1'b0; stb = 1'b0; end
      @(posedge clock); #1;
    end
    cyc = 1'b0; stb = 1'b0;
    if (lat > 0) begin
      @(posedge clock); #1;
      tail_clean = !ack && !err && (dat_r == 32'h0);
    end
  endtask

  task automatic run_model(input logic [31:0] a, input logic w, input logic [3:0] s,
                           input logic [31:0] d, input logic [7:0] wc);
    logic [31:0] idx, exp_dat, gd;
    logic        inr, ga, ge, tc;
    int          lat;
    idx = a >> 2;
    inr = idx < 32'd1024;
    exp_dat = (inr && !w) ? mem_m[idx[9:0]] : 32'h0;
    xfer(a, w, s, d, wc, -1, ga, ge, gd, lat, tc);
    check("model_resp", {30'b0, ga, ge}, {30'b0, inr, !inr});
    check("model_lat", 32'(lat), 32'(wc) + 32'd1);
    if (!w) check("model_rdata", gd, exp_dat);
    check("model_pulse", {31'b0, tc}, 32'd1);
    if (inr && w) mem_m[idx[9:0]] = merge(mem_m[idx[9:0]], d, s);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    logic        ga, ge, tc;
    logic [31:0] gd, idx;
    int          lat;

    tv[0]  = '{32'h10,       1'b1, 4'hF, 32'hDEADBEEF, 8'd0,   2'b10, 32'h0};
    tv[1]  = '{32'h10,       1'b0, 4'hF, 32'h0,        8'd0,   2'b10, 32'hDEADBEEF};
    tv[2]  = '{32'h20,       1'b1, 4'hF, 32'hFFFFFFFF, 8'd0,   2'b10, 32'h0};
    tv[3]  = '{32'h20,       1'b1, 4'h5, 32'h00000000, 8'd0,   2'b10, 32'h0};
    tv[4]  = '{32'h20,       1'b0, 4'h0, 32'h0,        8'd0,   2'b10, 32'hFF00FF00};
    tv[5]  = '{32'h0,        1'b1, 4'hF, 32'hA5A5A5A5, 8'd1,   2'b10, 32'h0};
    tv[6]  = '{32'h1000,     1'b0, 4'hF, 32'h0,        8'd0,   2'b01, 32'h0};
    tv[7]  = '{32'h1000,     1'b1, 4'hF, 32'h12345678, 8'd2,   2'b01, 32'h0};
    tv[8]  = '{32'h0,        1'b0, 4'hF, 32'h0,        8'd0,   2'b10, 32'hA5A5A5A5};
    tv[9]  = '{32'h13,       1'b0, 4'h1, 32'h0,        8'd3,   2'b10, 32'hDEADBEEF};
    tv[10] = '{32'hFFC,      1'b1, 4'hF, 32'h0BADF00D, 8'd1,   2'b10, 32'h0};
    tv[11] = '{32'hFFF,      1'b0, 4'hF, 32'h0,        8'd2,   2'b10, 32'h0BADF00D};
    tv[12] = '{32'h40,       1'b1, 4'hF, 32'h11111111, 8'd0,   2'b10, 32'h0};
    tv[13] = '{32'hFFFFFFF0, 1'b0, 4'hF, 32'h0,        8'd0,   2'b01, 32'h0};
    tv[14] = '{32'h40,       1'b0, 4'hF, 32'h0,        8'd255, 2'b10, 32'h11111111};

    reset = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    adr = 32'h0; dat_w = 32'h0; wait_cyc = 8'h0;
    #12;
    check("reset_ack", {31'b0, ack}, 32'd0);
    check("reset_err", {31'b0, err}, 32'd0);
    check("reset_dat_r", dat_r, 32'h0);
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;

    for (int i = 0; i < 64; i++) run_model(32'(i) << 2, 1'b1, 4'hF, $urandom, 8'd0);

    for (int i = 0; i < 15; i++) begin
      xfer(tv[i].a, tv[i].w, tv[i].s, tv[i].d, tv[i].wc, -1, ga, ge, gd, lat, tc);
      check($sformatf("vec%0d_resp", i), {30'b0, ga, ge}, {30'b0, tv[i].exp_resp});
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(tv[i].wc) + 32'd1);
      if (!tv[i].w) check($sformatf("vec%0d_rdata", i), gd, tv[i].exp_dat);
      check($sformatf("vec%0d_pulse", i), {31'b0, tc}, 32'd1);
      idx = tv[i].a >> 2;
      if (tv[i].w && idx < 32'd1024) mem_m[idx[9:0]] = merge(mem_m[idx[9:0]], tv[i].d, tv[i].s);
    end

    // cyc dropped in the 2nd and in the final WAIT cycle of a write
    xfer(32'h40, 1'b1, 4'hF, 32'h22222222, 8'd5, 1, ga, ge, gd, lat, tc);
    check("abort2_resp", {30'b0, ga, ge}, 32'd0);
    xfer(32'h40, 1'b1, 4'hF, 32'h22222222, 8'd5, 4, ga, ge, gd, lat, tc);
    check("abort_last_resp", {30'b0, ga, ge}, 32'd0);
    xfer(32'h40, 1'b0, 4'hF, 32'h0, 8'd0, -1, ga, ge, gd, lat, tc);
    check("abort_readback", gd, 32'h11111111);

    // stb without cyc must never start a transfer
    stb = 1'b1; cyc = 1'b0; adr = 32'h40; we = 1'b0; wait_cyc = 8'd0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      check("stb_only", {30'b0, ack, err}, 32'd0);
    end
    stb = 1'b0;

    // reset during WAIT of a write: no write, no response
    adr = 32'h40; we = 1'b1; sel = 4'hF; dat_w = 32'h33333333; wait_cyc = 8'd4;
    cyc = 1'b1; stb = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1; cyc = 1'b0; stb = 1'b0;
    #1;
    check("rst_wait_out", {dat_r[29:0], ack, err}, 32'd0);
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    xfer(32'h40, 1'b0, 4'hF, 32'h0, 8'd2, -1, ga, ge, gd, lat, tc);
    check("rst_after_resp", {30'b0, ga, ge}, 32'd2);
    check("rst_after_lat", 32'(lat), 32'd3);
    check("rst_after_data", gd, 32'h11111111);

    // reset while ack is high clears outputs asynchronously
    adr = 32'h40; we = 1'b0; wait_cyc = 8'd0; cyc = 1'b1; stb = 1'b1;
    @(posedge clock); #1;
    check("resp_ack_before_rst", {31'b0, ack}, 32'd1);
    check("resp_dat_before_rst", dat_r, 32'h11111111);
    reset = 1'b1; cyc = 1'b0; stb = 1'b0;
    #1;
    check("resp_ack_after_rst", {31'b0, ack}, 32'd0);
    check("resp_dat_after_rst", dat_r, 32'h0);
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;

    for (int n = 0; n < 200; n++) begin
      logic [31:0] widx, a;
      if ($urandom_range(0, 9) == 0) widx = 32'd1024 + $urandom_range(0, 5000);
      else widx = $urandom_range(0, 63);
      a = (widx << 2) | 32'($urandom_range(0, 3));
      run_model(a, 1'($urandom_range(0, 1)), 4'($urandom), $urandom,
                8'($urandom_range(0, 4)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
